mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle CPU datapath.
- Sits directly downstream of the register file read ports. src_a and src_b come from rdata_A and rdata_B.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles into HI/LO registers. Control stalls on busy; MFHI/MFLO results go back to the register file write port.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; the counter width is log2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  XLEN  multiplicand / dividend (from rdata_A)
- src_b  in  XLEN  multiplier / divisor (from rdata_B)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle
- div_by_zero  out  1  set on completion of DIV/DIVU with src_b==0
- hi  out  XLEN  HI register (product upper half / remainder)
- lo  out  XLEN  LO register (product lower half / quotient)

Behaviour:
- Reset (rst==0, asynchronous):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
  - Reset asserted mid-operation aborts the operation; no partial result is written to hi/lo.
- States: IDLE -> CALC -> FIX -> IDLE. busy = (state != IDLE), decoded from the state register.
- IDLE:
  - On start=1, latch op, src_a, src_b, sign flags and operand magnitudes. Magnitudes are two's-complement absolute values for signed ops; raw values for unsigned ops.
  - Clear counter, clear div_by_zero, go to CALC.
  - start=0: remain in IDLE; hi/lo hold.
- CALC: one iteration per clock, exactly XLEN iterations (counter 0..XLEN-1), then go to FIX.
  - Multiply: shift-add on magnitudes into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- FIX (single edge): apply sign correction and write hi/lo. Then pulse done=1 for exactly one cycle and return to IDLE.
  - MULT: negate the 2*XLEN product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- Latency:
  - start is sampled on edge E0.
  - done and valid hi/lo are visible after edge E(XLEN+1), i.e. 33 edges later.
  - busy is high after E0 through E(XLEN+1); it falls on the same edge that done rises.
  - Latency is fixed for all ops and operands.
- start while busy: ignored; the in-flight operation is unaffected.
- start in the done cycle: accepted, since state is already IDLE. A back-to-back issue gives one cycle of done and no bubble.
- Divide by zero (DIV/DIVU, src_b==0): same latency as a normal divide. On completion hi=src_a (as latched), lo={XLEN{1'b1}}, div_by_zero=1. div_by_zero holds until the next accepted start.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (result modulo 2^XLEN, no flag).
- hi/lo change only on the FIX edge or on reset. They are readable at any time and show the previous result while busy.
- Operand inputs may change freely after the start edge; the unit uses only the latched copies.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done exactly 33 edges after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy low in the done cycle.
- MULT 0xFFFFFFFD (-3) * 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then a back-to-back start in the done cycle with MULTU 7*6 -> hi=0, lo=0x2A.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 0x64 / 0 -> hi=0x64, lo=0xFFFFFFFF, div_by_zero=1. A following MULTU 1*1 clears div_by_zero on its start edge.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start a DIVU, then pulse start with new operands at cycle 10 (ignored), then assert rst=0 at cycle 20 -> busy=0, done=0, hi=lo=0 immediately (asynchronous). No done pulse appears afterwards.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// fixed latency of XLEN+1 edges from the accepted start to the done pulse.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_m;
  logic [XLEN-1:0]   r_a_raw;
  logic              r_is_div;
  logic              r_sa;
  logic              r_sb;
  logic              r_zero_div;
  logic              r_done;
  logic              r_dbz;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  // Handshake: start is a one-cycle request honoured only in IDLE (including the
  // done cycle); done is a one-cycle pulse with hi/lo valid in that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CW'(XLEN - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  assign w_sign_a = op[0] & src_a[XLEN-1];
  assign w_sign_b = op[0] & src_b[XLEN-1];
  assign w_mag_a  = w_sign_a ? -src_a : src_a;
  assign w_mag_b  = w_sign_b ? -src_b : src_b;

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_step;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_step = {w_sum, r_acc[XLEN-1:1]};

  // Divide step: shift {rem, quotient} left, subtract divisor when it fits.
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_step;
  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_m});
  assign w_diff     = w_shift[XLEN-1:0] - r_m;
  assign w_div_step = {(w_ge ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;
  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_hi = w_prod[2*XLEN-1:XLEN];
    w_fix_lo = w_prod[XLEN-1:0];
    if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
      if (r_zero_div) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_m        <= '0;
      r_a_raw    <= '0;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_zero_div <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div   <= op[1];
            r_sa       <= w_sign_a;
            r_sb       <= w_sign_b;
            r_a_raw    <= src_a;
            r_zero_div <= op[1] && (src_b == '0);
            r_acc      <= {{XLEN{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
            r_m        <= op[1] ? w_mag_b : w_mag_a;
            r_cnt      <= '0;
            r_dbz      <= 1'b0;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_dbz  <= r_is_div & r_zero_div;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, MULT/DIV results, back-to-back
// issue, divide by zero, signed overflow, ignored start and reset abort.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  mul_div_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns 1 ns after the start edge E0 with
  // operands scrambled so only the latched copies can matter.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  // Counts edges after E0 until done is seen, bounded at 40.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int n;
    start_op(o, a, b);
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(0, n);
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b1;
    tick();
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // MULT -3*5, then issue MULTU 7*6 in its done cycle
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    start_op(OP_MULTU, 32'd7, 32'd6);
    check("b2b_done_once", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold_lo", lo, 32'hFFFF_FFF1);
    wait_done(0, n);
    check("b2b_latency", 32'(n), 32'd33);
    check("b2b_hi", hi, 32'h0);
    check("b2b_lo", lo, 32'h0000_002A);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // DIVU 100/7 with an ignored start pulse at cycle 10
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    start = 1'b1;
    op    = OP_MULTU;
    src_a = 32'h1234_5678;
    src_b = 32'h0000_0003;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(10, n);
    check("divu_latency", 32'(n), 32'd33);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    tick();
    check("divu_done_pulse", 32'(done), 32'd0);

    run_op("dbz", OP_DIVU, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    tick();
    tick();
    check("dbz_hold", 32'(div_by_zero), 32'd1);
    start_op(OP_MULTU, 32'd1, 32'd1);
    check("dbz_clear", 32'(div_by_zero), 32'd0);
    wait_done(0, n);
    check("mul1_latency", 32'(n), 32'd33);
    check("mul1_hi", hi, 32'h0);
    check("mul1_lo", lo, 32'h1);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // Reset abort in the middle of a DIVU
    start_op(OP_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) tick();
    start = 1'b1;
    src_a = 32'd9;
    src_b = 32'd2;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_lo", lo, 32'h8000_0000);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    tick();
    #3;
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_lo_kept", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
